vcu_dual_arbiter: RTL and testbench
===================================

// Module: vcu_dual_arbiter
// PURPOSE
//   Shares one video control unit (VCU) command port between two sr_cpu_vc cores (p0, p1).
//   Each core gets a control shadow register, a one-entry command slot and a private tick timer.
//   A round-robin FSM forwards slots to the VCU over a valid/ready handshake.
//   Each core's vcu_reg_rdata returns timer and slot status.
// PARAMETERS
//   DATA_W     32             width of control/data words
//   TICK_LOAD  28'h2FAF080    tick timer reload value (benches use 28'h10)
// PORTS
//   clk                    in   1       system clock, single domain
//   reset_p                in   1       reset, asynchronous, active-high
//   p0_vcu_reg_control     in   DATA_W  core0 control word
//   p0_vcu_reg_control_we  in   1       core0 control write strobe
//   p0_vcu_reg_wdata       in   DATA_W  core0 data word
//   p0_vcu_reg_wdata_we    in   1       core0 data write strobe (issues a command)
//   p0_vcu_reg_rdata       out  DATA_W  core0 status
//   p1_vcu_reg_*           same five ports for core1
//   vcu_cmd_valid          out  1       command presented to VCU
//   vcu_cmd_ready          in   1       VCU accepts command this cycle
//   vcu_cmd_src            out  1       0 = from core0, 1 = from core1
//   vcu_cmd_ctrl           out  DATA_W  control word of command
//   vcu_cmd_data           out  DATA_W  data word of command
// BEHAVIOUR
//   Reset (async, immediate):
//   - slots empty, overflow flags 0, ctrl shadows 0, state IDLE
//   - last_src=1, so core0 wins the first tie
//   - timers load TICK_LOAD; all vcu_cmd_* outputs 0; rdata[31:1]=0
//   Ctrl shadow (per core): control_we -> shadow <= control; also clears that core's overflow flag.
//   Command capture on wdata_we, per core:
//   - slot empty, or being accepted this cycle: slot <= {ctrl, wdata}, pending <= 1
//   - ctrl is the shadow, or the new control value if control_we is in the same cycle
//   - slot full and not accepted this cycle: write dropped, overflow <= 1 (sticky)
//   FSM states IDLE, GRANT0, GRANT1:
//   - IDLE -> GRANTx if only core x pending
//   - both pending -> GRANTx where x != last_src
//   - GRANTx: vcu_cmd_valid=1, src=x, ctrl/data = slot x
//   - GRANTx -> IDLE on valid&&ready; slot x cleared, last_src <= x
//   - GRANTx, ready=0: hold state; all outputs stable (slot x is frozen)
//   - not in GRANT: valid=0, src=0, ctrl=0, data=0
//   Latency and throughput:
//   - wdata_we sampled at edge t -> valid high from edge t+1 (the IDLE->GRANT transition)
//   - max throughput: 1 command per 2 cycles
//   Tick timer (per core, 28 bit):
//   - reload TICK_LOAD on reset or own wdata_we
//   - else decrement while bit27==0; freezes once bit27=1
//   - from TICK_LOAD=16: bit27 rises after 17 decrements
//   rdata per core: [0] timer bit27 (tick done), [1] pending, [2] overflow, [31:3] 0.
//   Reset mid-handshake: valid drops asynchronously; pending commands discarded, never replayed.
// TESTING
//   1. p0 control_we=3, then wdata_we=0x55, ready=1
//      -> valid=1 one cycle after the write, src=0, ctrl=3, data=0x55
//      -> p0 rdata[1] back to 0 after accept
//   2. p0 0xA0 and p1 0xB0 written same cycle, ready=1
//      -> 0xA0 (src0) then 0xB0 (src1), 2 cycles apart
//      -> next simultaneous pair served core0 first
//   3. ready=0 for 5 cycles with p0 0x11 pending, second p0 write 0x22
//      -> outputs hold 0x11, p0 rdata[2]=1
//      -> ready=1 delivers only 0x11; p0 control_we clears rdata[2]
//   4. Second p0 write lands in the same cycle as the accept
//      -> no overflow; the second value is issued 2 cycles later
//   5. TICK_LOAD=16, p0 wdata_we -> p0 rdata[0]=0 for 17 cycles then 1
//      -> p1 timer unaffected
//   6. reset_p pulsed while valid=1 -> valid=0 same cycle, rdata[1]=0
//      -> no command issued after reset release

Source files
------------

// File: rtl/vcu_dual_arbiter_if.sv
// VCU command port: valid/ready handshake carrying source id, control and data words.
interface vcu_dual_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic              src;
  logic [DATA_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, src, ctrl, data, input ready);
  modport slave  (input valid, src, ctrl, data, output ready);
endinterface

// File: rtl/vcu_dual_arbiter.sv
// Shares one VCU command port between two cores: per-core ctrl shadow, one-entry slot,
// tick timer, and a round-robin grant FSM.
//   state  | meaning
//   IDLE   | no command presented; picks next pending slot
//   GRANT0 | core0 slot presented on the VCU port
//   GRANT1 | core1 slot presented on the VCU port
module vcu_dual_arbiter #(
  parameter int          DATA_W    = 32,
  parameter logic [27:0] TICK_LOAD = 28'h2FAF080
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic [DATA_W-1:0] p0_vcu_reg_control,
  input  logic              p0_vcu_reg_control_we,
  input  logic [DATA_W-1:0] p0_vcu_reg_wdata,
  input  logic              p0_vcu_reg_wdata_we,
  output logic [DATA_W-1:0] p0_vcu_reg_rdata,
  input  logic [DATA_W-1:0] p1_vcu_reg_control,
  input  logic              p1_vcu_reg_control_we,
  input  logic [DATA_W-1:0] p1_vcu_reg_wdata,
  input  logic              p1_vcu_reg_wdata_we,
  output logic [DATA_W-1:0] p1_vcu_reg_rdata,
  vcu_dual_arbiter_if.master cmd
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t            state, state_nxt;
  logic              last_src;
  logic [DATA_W-1:0] ctrl_in   [2];
  logic [DATA_W-1:0] wdata_in  [2];
  logic [DATA_W-1:0] shadow    [2];
  logic [DATA_W-1:0] slot_ctrl [2];
  logic [DATA_W-1:0] slot_data [2];
  logic [27:0]       timer     [2];
  logic [1:0]        ctrl_we, wdata_we, pend, ovf, accept;

  assign ctrl_in[0]  = p0_vcu_reg_control;
  assign ctrl_in[1]  = p1_vcu_reg_control;
  assign wdata_in[0] = p0_vcu_reg_wdata;
  assign wdata_in[1] = p1_vcu_reg_wdata;
  assign ctrl_we     = {p1_vcu_reg_control_we, p0_vcu_reg_control_we};
  assign wdata_we    = {p1_vcu_reg_wdata_we, p0_vcu_reg_wdata_we};
  assign accept      = {(state == GRANT1) && cmd.ready, (state == GRANT0) && cmd.ready};

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      for (int i = 0; i < 2; i++) begin
        shadow[i]    <= '0;
        slot_ctrl[i] <= '0;
        slot_data[i] <= '0;
        timer[i]     <= TICK_LOAD;
      end
      pend <= '0;
      ovf  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ctrl_we[i]) begin
          shadow[i] <= ctrl_in[i];
          ovf[i]    <= 1'b0;
        end
        if (wdata_we[i]) begin
          timer[i] <= TICK_LOAD;
          // A slot being accepted this cycle is free to take the new command.
          if (!pend[i] || accept[i]) begin
            slot_ctrl[i] <= ctrl_we[i] ? ctrl_in[i] : shadow[i];
            slot_data[i] <= wdata_in[i];
            pend[i]      <= 1'b1;
          end else begin
            ovf[i] <= 1'b1;
          end
        end else begin
          if (accept[i]) pend[i] <= 1'b0;
          if (!timer[i][27]) timer[i] <= timer[i] - 28'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state    <= IDLE;
      last_src <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept[0])      last_src <= 1'b0;
      else if (accept[1]) last_src <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd.valid = 1'b0;
    cmd.src   = 1'b0;
    cmd.ctrl  = '0;
    cmd.data  = '0;
    case (state)
      IDLE: begin
        if (pend[0] && pend[1]) state_nxt = last_src ? GRANT0 : GRANT1;
        else if (pend[0])       state_nxt = GRANT0;
        else if (pend[1])       state_nxt = GRANT1;
      end
      GRANT0: begin
        cmd.valid = 1'b1;
        cmd.ctrl  = slot_ctrl[0];
        cmd.data  = slot_data[0];
        if (cmd.ready) state_nxt = IDLE;
      end
      GRANT1: begin
        cmd.valid = 1'b1;
        cmd.src   = 1'b1;
        cmd.ctrl  = slot_ctrl[1];
        cmd.data  = slot_data[1];
        if (cmd.ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    p0_vcu_reg_rdata      = '0;
    p1_vcu_reg_rdata      = '0;
    p0_vcu_reg_rdata[2:0] = {ovf[0], pend[0], timer[0][27]};
    p1_vcu_reg_rdata[2:0] = {ovf[1], pend[1], timer[1][27]};
  end
endmodule

// File: tb/tb_vcu_dual_arbiter.sv
// Directed bench for vcu_dual_arbiter: vector table for arbitration, plus
// hand sequences for backpressure/overflow, tick timer and mid-handshake reset.
module tb_vcu_dual_arbiter;
  logic        clk = 1'b0;
  logic        reset_p;
  logic [31:0] c0, w0, r0, c1, w1, r1;
  logic        cwe0, we0, cwe1, we1;
  int          checks = 0;
  int          failures = 0;

  vcu_dual_arbiter_if #(.DATA_W(32)) cmd_if ();

  vcu_dual_arbiter #(.DATA_W(32), .TICK_LOAD(28'h10)) dut (
    .clk                  (clk),
    .reset_p              (reset_p),
    .p0_vcu_reg_control   (c0),
    .p0_vcu_reg_control_we(cwe0),
    .p0_vcu_reg_wdata     (w0),
    .p0_vcu_reg_wdata_we  (we0),
    .p0_vcu_reg_rdata     (r0),
    .p1_vcu_reg_control   (c1),
    .p1_vcu_reg_control_we(cwe1),
    .p1_vcu_reg_wdata     (w1),
    .p1_vcu_reg_wdata_we  (we1),
    .p1_vcu_reg_rdata     (r1),
    .cmd                  (cmd_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] c0;  logic cwe0; logic [31:0] w0; logic we0;
    logic [31:0] c1;  logic cwe1; logic [31:0] w1; logic we1;
    logic        rdy;
    logic        ev;  logic es;   logic [31:0] ec; logic [31:0] ed;
    logic [1:0]  st0; logic [1:0] st1;   // {overflow, pending}
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic [31:0] c0_, input logic cwe0_, input logic [31:0] w0_,
                              input logic we0_, input logic [31:0] c1_, input logic cwe1_,
                              input logic [31:0] w1_, input logic we1_, input logic rdy_,
                              input logic ev_, input logic es_, input logic [31:0] ec_,
                              input logic [31:0] ed_, input logic [1:0] st0_, input logic [1:0] st1_);
    vec_t v;
    v.c0 = c0_; v.cwe0 = cwe0_; v.w0 = w0_; v.we0 = we0_;
    v.c1 = c1_; v.cwe1 = cwe1_; v.w1 = w1_; v.we1 = we1_;
    v.rdy = rdy_; v.ev = ev_; v.es = es_; v.ec = ec_; v.ed = ed_;
    v.st0 = st0_; v.st1 = st1_;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cwe0 = 1'b0; we0 = 1'b0; cwe1 = 1'b0; we1 = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic es,
                         input logic [31:0] ec, input logic [31:0] ed);
    chk({tag, ".valid"}, {31'b0, cmd_if.valid}, {31'b0, ev});
    chk({tag, ".src"},   {31'b0, cmd_if.src},   {31'b0, es});
    chk({tag, ".ctrl"},  cmd_if.ctrl, ec);
    chk({tag, ".data"},  cmd_if.data, ed);
  endtask

  initial begin
    reset_p = 1'b1;
    c0 = '0; w0 = '0; c1 = '0; w1 = '0;
    idle_inputs();
    cmd_if.ready = 1'b0;

    // Simultaneous pair after reset: core0 first, then core1.
    vecs[0]  = mk(0,0,32'hA0,1, 0,0,32'hB0,1, 1,  0,0,0,0,       2'b01,2'b01);
    vecs[1]  = mk(0,0,0,0,      0,0,0,0,      1,  1,0,0,32'hA0,  2'b01,2'b01);
    vecs[2]  = mk(0,0,0,0,      0,0,0,0,      1,  0,0,0,0,       2'b00,2'b01);
    vecs[3]  = mk(0,0,0,0,      0,0,0,0,      1,  1,1,0,32'hB0,  2'b00,2'b01);
    vecs[4]  = mk(0,0,0,0,      0,0,0,0,      1,  0,0,0,0,       2'b00,2'b00);
    // Next pair: core0 again first; core1 ctrl written in the same cycle as its data.
    vecs[5]  = mk(0,0,32'hC0,1, 7,1,32'hD0,1, 1,  0,0,0,0,       2'b01,2'b01);
    vecs[6]  = mk(0,0,0,0,      0,0,0,0,      1,  1,0,0,32'hC0,  2'b01,2'b01);
    vecs[7]  = mk(0,0,0,0,      0,0,0,0,      1,  0,0,0,0,       2'b00,2'b01);
    vecs[8]  = mk(0,0,0,0,      0,0,0,0,      1,  1,1,7,32'hD0,  2'b00,2'b01);
    vecs[9]  = mk(0,0,0,0,      0,0,0,0,      1,  0,0,0,0,       2'b00,2'b00);
    // Single command with control shadow 3.
    vecs[10] = mk(3,1,0,0,      0,0,0,0,      1,  0,0,0,0,       2'b00,2'b00);
    vecs[11] = mk(0,0,32'h55,1, 0,0,0,0,      1,  0,0,0,0,       2'b01,2'b00);
    vecs[12] = mk(0,0,0,0,      0,0,0,0,      1,  1,0,3,32'h55,  2'b01,2'b00);
    vecs[13] = mk(0,0,0,0,      0,0,0,0,      1,  0,0,0,0,       2'b00,2'b00);
    // Second write in the accept cycle: no overflow, reissued two cycles later.
    vecs[14] = mk(0,0,32'h66,1, 0,0,0,0,      1,  0,0,0,0,       2'b01,2'b00);
    vecs[15] = mk(0,0,0,0,      0,0,0,0,      1,  1,0,3,32'h66,  2'b01,2'b00);
    vecs[16] = mk(0,0,32'h77,1, 0,0,0,0,      1,  0,0,0,0,       2'b01,2'b00);
    vecs[17] = mk(0,0,0,0,      0,0,0,0,      1,  1,0,3,32'h77,  2'b01,2'b00);
    vecs[18] = mk(0,0,0,0,      0,0,0,0,      1,  0,0,0,0,       2'b00,2'b00);

    #2;
    chk_out("reset", 1'b0, 1'b0, 32'h0, 32'h0);
    chk("reset.rdata0", r0, 32'h0);
    chk("reset.rdata1", r1, 32'h0);
    step();
    step();
    reset_p = 1'b0;

    for (int i = 0; i < 19; i++) begin
      c0 = vecs[i].c0; cwe0 = vecs[i].cwe0; w0 = vecs[i].w0; we0 = vecs[i].we0;
      c1 = vecs[i].c1; cwe1 = vecs[i].cwe1; w1 = vecs[i].w1; we1 = vecs[i].we1;
      cmd_if.ready = vecs[i].rdy;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].es, vecs[i].ec, vecs[i].ed);
      chk($sformatf("vec%0d.st0", i), {30'b0, r0[2:1]}, {30'b0, vecs[i].st0});
      chk($sformatf("vec%0d.st1", i), {30'b0, r1[2:1]}, {30'b0, vecs[i].st1});
    end
    idle_inputs();

    // Backpressure: 0x11 held for 5 cycles, 0x22 dropped with overflow.
    cmd_if.ready = 1'b0;
    w0 = 32'h11; we0 = 1'b1;
    step();
    we0 = 1'b0;
    step();
    chk_out("bp.grant", 1'b1, 1'b0, 32'h3, 32'h11);
    w0 = 32'h22; we0 = 1'b1;
    step();
    we0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk_out($sformatf("bp.hold%0d", k), 1'b1, 1'b0, 32'h3, 32'h11);
      chk($sformatf("bp.ovf%0d", k), {31'b0, r0[2]}, 32'h1);
      step();
    end
    cmd_if.ready = 1'b1;
    step();
    chk_out("bp.accepted", 1'b0, 1'b0, 32'h0, 32'h0);
    chk("bp.pend_clear", {31'b0, r0[1]}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("bp.no_replay%0d", k), {31'b0, cmd_if.valid}, 32'h0);
    end
    chk("bp.ovf_sticky", {31'b0, r0[2]}, 32'h1);
    c0 = 32'h3; cwe0 = 1'b1;
    step();
    cwe0 = 1'b0;
    chk("bp.ovf_cleared", {31'b0, r0[2]}, 32'h0);

    // Tick timer: reload on write, 17 cycles low, then high; p1 unaffected.
    for (int k = 0; k < 20; k++) step();
    chk("tick.p0_done_before", {31'b0, r0[0]}, 32'h1);
    chk("tick.p1_done_before", {31'b0, r1[0]}, 32'h1);
    w0 = 32'h5A; we0 = 1'b1;
    step();
    we0 = 1'b0;
    for (int k = 0; k < 17; k++) begin
      chk($sformatf("tick.p0_low%0d", k), {31'b0, r0[0]}, 32'h0);
      chk($sformatf("tick.p1_high%0d", k), {31'b0, r1[0]}, 32'h1);
      step();
    end
    chk("tick.p0_done", {31'b0, r0[0]}, 32'h1);
    step();
    chk("tick.p0_frozen", {31'b0, r0[0]}, 32'h1);

    // Reset mid-handshake: valid drops immediately and nothing is replayed.
    cmd_if.ready = 1'b0;
    w0 = 32'h99; we0 = 1'b1;
    step();
    we0 = 1'b0;
    step();
    chk_out("rst.grant", 1'b1, 1'b0, 32'h3, 32'h99);
    reset_p = 1'b1;
    #1;
    chk_out("rst.async", 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rst.rdata0", r0, 32'h0);
    step();
    reset_p = 1'b0;
    cmd_if.ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rst.no_cmd%0d", k), {31'b0, cmd_if.valid}, 32'h0);
      chk($sformatf("rst.pend%0d", k), {31'b0, r0[1]}, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
